inst_mem_port_arbiter: RTL and testbench
========================================

// Module: inst_mem_port_arbiter
// PURPOSE
//  N-requester to single-memory-port arbiter for the instruction subsystem (core fetch path, AXI4 adapter, debug/loader).
//  Requester and memory ports use the CORE_DATA_INF req/gnt/rvalid protocol; one memory port is shared by all requesters.
//  Supports round-robin or fixed-priority arbitration and holds the selection while the memory stalls.
//  Tracks up to MAX_OUTSTANDING granted reads/writes and routes each mem_rvalid_i back to the requester that issued it.
// PARAMETERS
//  NUM_PORTS        2   number of requesters (2..8)
//  ADDR_WIDTH       32  address width
//  DATA_WIDTH       32  data width; byte-enable width = DATA_WIDTH/8
//  MAX_OUTSTANDING  2   max granted-but-unanswered transactions (1..8); depth of the ID FIFO
//  ARB_MODE         0   0 = round-robin, 1 = fixed priority (port 0 highest)
// PORTS
//  clk_i            in   1                  clock
//  rst_ni           in   1                  asynchronous active-low reset
//  req_i            in   NUM_PORTS          per-port request
//  gnt_o            out  NUM_PORTS          per-port grant (one-hot or zero)
//  addr_i           in   NUM_PORTS*AW       packed per-port address; port i at [i*AW +: AW]
//  we_i             in   NUM_PORTS          per-port write enable
//  be_i             in   NUM_PORTS*DW/8     packed per-port byte enables
//  wdata_i          in   NUM_PORTS*DW       packed per-port write data
//  rvalid_o         out  NUM_PORTS          per-port response valid (one-hot or zero)
//  rdata_o          out  DW                 response data, broadcast to all ports
//  mem_req_o        out  1                  memory request
//  mem_gnt_i        in   1                  memory grant
//  mem_addr_o       out  AW                 memory address
//  mem_we_o         out  1                  memory write enable
//  mem_be_o         out  DW/8               memory byte enables
//  mem_wdata_o      out  DW                 memory write data
//  mem_rvalid_i     in   1                  memory response valid (one per granted transaction, in order)
//  mem_rdata_i      in   DW                 memory response data
//  unexp_rvalid_o   out  1                  pulse: mem_rvalid_i while no transaction outstanding
// BEHAVIOUR
//  - State: priority pointer ptr (clog2 NUM_PORTS), lock flag + locked index, ID FIFO (MAX_OUTSTANDING entries), count.
//  - Reset (rst_ni low, async): ptr=0, lock=0, FIFO empty, count=0. With the FIFO empty, rvalid_o=0 and unexp_rvalid_o=0.
//  - full = (count == MAX_OUTSTANDING). While full: mem_req_o=0 and gnt_o=0. A pop in the same cycle does not lift the block (no bypass).
//  - Winner when not locked:
//    - RR mode: first asserted req_i at or after ptr, searching upward and wrapping at NUM_PORTS-1 -> 0.
//    - Fixed mode: lowest asserted index.
//  - While locked, winner = locked index, regardless of other requests.
//  - mem_req_o = !full & (lock | |req_i).
//  - mem_addr/we/be/wdata_o = winner's fields. All are combinational, with zero added latency.
//  - Handshake = mem_req_o & mem_gnt_i. gnt_o[winner] = handshake; all other gnt_o bits = 0.
//  - On a handshake:
//    - Push the winner index into the FIFO and clear lock.
//    - In RR mode, ptr <= (winner+1) mod NUM_PORTS. In fixed mode, ptr is unused and stays 0.
//  - On mem_req_o & !mem_gnt_i: lock <= 1, locked index <= winner. The selection is held until the grant arrives.
//  - Requesters must hold req_i and their fields until granted (protocol rule). Dropping req_i while locked is illegal; the assertion fires.
//  - Responses:
//    - On mem_rvalid_i with count>0: rvalid_o[FIFO head] = 1 and pop.
//    - rdata_o = mem_rdata_i (combinational pass-through).
//  - On mem_rvalid_i with count==0: unexp_rvalid_o=1 for that cycle. No pop, no rvalid_o, no state change.
//  - Simultaneous push and pop: count unchanged; the head advances and the new entry is written at the tail.
//  - Minimum round trip: grant in cycle T, rvalid earliest at T+1 (memory dependent). A back-to-back grant every cycle is allowed while not full.
//  - Reset asserted mid-transaction:
//    - All outstanding IDs are discarded.
//    - Any later stale mem_rvalid_i raises unexp_rvalid_o.
//  - Assertions (disabled in reset):
//    - gnt_o and rvalid_o are each onehot0.
//    - No push when full.
//    - A locked port keeps req_i high.
//    - NUM_PORTS and MAX_OUTSTANDING are within range.
// TESTING
//  T1 RR fairness:
//     - Setup: NUM_PORTS=3, all req_i=3'b111, mem_gnt_i=1, 1-cycle memory.
//     - Required: grants in order 0,1,2,0,1,2. Each rvalid_o[i] arrives one cycle after gnt_o[i].
//  T2 Fixed priority:
//     - Setup: ARB_MODE=1, req_i=3'b110 then 3'b111.
//     - Required: port 1 is granted; once port 0 requests, port 0 wins every cycle.
//  T3 Stall lock:
//     - Setup: port 2 is selected with mem_gnt_i=0 for 3 cycles while port 0 raises req.
//     - Required: mem_addr_o holds port 2's address; grant goes to port 2 in cycle 4, port 0 next.
//  T4 Outstanding limit:
//     - Setup: MAX_OUTSTANDING=2, withhold mem_rvalid_i.
//     - Required: after 2 grants, mem_req_o=0. One rvalid releases exactly one more grant, a cycle later.
//  T5 Routing:
//     - Setup: grant port 1, then port 0; return rdata 0xAAAA_0001, then 0xBBBB_0000.
//     - Required: rvalid_o=2'b10 with 0xAAAA_0001, then 2'b01 with 0xBBBB_0000.
//  T6 Reset / spurious:
//     - Setup: assert rst_ni=0 with 2 outstanding, release it, then pulse mem_rvalid_i.
//     - Required: unexp_rvalid_o=1, rvalid_o=0, ptr=0.

Source files
------------

// File: rtl/inst_mem_port_arbiter.sv
// Shares one CORE_DATA_INF memory port between NUM_PORTS requesters.
// Round-robin or fixed priority, stall lock, in-order response routing.
module inst_mem_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ARB_MODE        = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              mem_req_o,
  input  logic                              mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic                              mem_we_o,
  output logic [DATA_WIDTH/8-1:0]           mem_be_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic                              mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  output logic                              unexp_rvalid_o
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = DATA_WIDTH / 8;

  logic [IW-1:0]          r_ptr;
  logic                   r_lock;
  logic [IW-1:0]          r_lock_idx;
  logic [IW-1:0]          r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]          r_wr;
  logic [PW-1:0]          r_rd;
  logic [CW-1:0]          r_count;

  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [NUM_PORTS-1:0]   w_rot;
  logic [IW-1:0]          w_rr_idx;
  logic [IW-1:0]          w_fp_idx;
  logic [IW-1:0]          w_win;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_hs;
  logic                   w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // rotate so that bit 0 of w_rot is the port at the pointer
  always_comb begin
    w_dbl    = {req_i, req_i};
    w_rot    = NUM_PORTS'(w_dbl >> r_ptr);
    w_rr_idx = r_ptr;
    w_fp_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_rr_idx = IW'((int'(r_ptr) + k) % NUM_PORTS);
      if (req_i[k]) w_fp_idx = IW'(k);
    end
  end

  assign w_win   = r_lock ? r_lock_idx :
                   (ARB_MODE == 1) ? w_fp_idx : w_rr_idx;
  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  assign mem_req_o      = !w_full && (r_lock || |req_i);
  assign w_hs           = mem_req_o && mem_gnt_i;
  assign w_pop          = mem_rvalid_i && !w_empty;
  assign unexp_rvalid_o = mem_rvalid_i && w_empty;
  assign rdata_o        = mem_rdata_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_win == IW'(i)) begin
        mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_we_o    = we_i[i];
        mem_be_o    = be_i[i*BW +: BW];
        mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      gnt_o[i]    = w_hs && (w_win == IW'(i));
      rvalid_o[i] = w_pop && (r_fifo[r_rd] == IW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
    end else begin
      if (w_hs) begin
        r_lock <= 1'b0;
        if (ARB_MODE == 0)
          r_ptr <= IW'((int'(w_win) + 1) % NUM_PORTS);
      end else if (mem_req_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_win;
      end
      if (w_hs)  r_wr <= f_inc(r_wr);
      if (w_pop) r_rd <= f_inc(r_rd);
      if (w_hs && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_hs && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        r_fifo[i] <= '0;
    end else if (w_hs) begin
      r_fifo[r_wr] <= w_win;
    end
  end

  a_params: assert property (@(posedge clk_i) disable iff (!rst_ni)
    NUM_PORTS >= 2 && NUM_PORTS <= 8 &&
    MAX_OUTSTANDING >= 1 && MAX_OUTSTANDING <= 8);
  a_gnt_oh: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_rv_oh: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rvalid_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_hs && w_full));
  a_lock_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_lock |-> |(req_i & (NUM_PORTS'(1) << r_lock_idx)));

endmodule

// File: tb/tb_inst_mem_port_arbiter.sv
// Bench for inst_mem_port_arbiter: RR and fixed-priority instances share
// stimulus; a queue-based model checks both every cycle.
module tb_inst_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*BW-1:0] be = '0;
  logic [N*DW-1:0] wdata = '0;
  logic            mgnt = 1'b0;
  logic            mrv = 1'b0;
  logic [DW-1:0]   mrdata = '0;

  logic [N-1:0]  gnt_r, rv_r, gnt_f, rv_f;
  logic [DW-1:0] rd_r, rd_f, ma_r, ma_f, mw_r, mw_f;
  logic [BW-1:0] mbe_r, mbe_f;
  logic          mreq_r, mreq_f, mwe_r, mwe_f, ux_r, ux_f;

  inst_mem_port_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MO), .ARB_MODE(0)
  ) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_r),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rv_r), .rdata_o(rd_r), .mem_req_o(mreq_r),
    .mem_gnt_i(mgnt), .mem_addr_o(ma_r), .mem_we_o(mwe_r),
    .mem_be_o(mbe_r), .mem_wdata_o(mw_r), .mem_rvalid_i(mrv),
    .mem_rdata_i(mrdata), .unexp_rvalid_o(ux_r)
  );

  inst_mem_port_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MO), .ARB_MODE(1)
  ) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_f),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rv_f), .rdata_o(rd_f), .mem_req_o(mreq_f),
    .mem_gnt_i(mgnt), .mem_addr_o(ma_f), .mem_we_o(mwe_f),
    .mem_be_o(mbe_f), .mem_wdata_o(mw_f), .mem_rvalid_i(mrv),
    .mem_rdata_i(mrdata), .unexp_rvalid_o(ux_f)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // model: m=0 round-robin, m=1 fixed priority
  int m_ptr [2];
  bit m_lock [2];
  int m_lidx [2];
  int m_q [2][$];

  function automatic int m_winner(input int m);
    if (m_lock[m]) return m_lidx[m];
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m == 1) ? k : (m_ptr[m] + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    int w;
    bit full, mreq, hs, pop, eux;
    logic [N-1:0] egnt, erv, a_gnt, a_rv;
    logic [DW-1:0] a_rd, a_ma, a_mw;
    logic [BW-1:0] a_be;
    logic a_mreq, a_we, a_ux;
    string p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int m = 0; m < 2; m++) begin
          m_ptr[m] = 0;
          m_lock[m] = 1'b0;
          m_lidx[m] = 0;
          m_q[m].delete();
        end
      end else begin
        for (int m = 0; m < 2; m++) begin
          p      = (m == 0) ? "rr" : "fp";
          a_gnt  = (m == 0) ? gnt_r : gnt_f;
          a_rv   = (m == 0) ? rv_r : rv_f;
          a_rd   = (m == 0) ? rd_r : rd_f;
          a_ma   = (m == 0) ? ma_r : ma_f;
          a_mw   = (m == 0) ? mw_r : mw_f;
          a_be   = (m == 0) ? mbe_r : mbe_f;
          a_mreq = (m == 0) ? mreq_r : mreq_f;
          a_we   = (m == 0) ? mwe_r : mwe_f;
          a_ux   = (m == 0) ? ux_r : ux_f;
          full = (m_q[m].size() == MO);
          mreq = !full && (m_lock[m] || req != '0);
          w    = m_winner(m);
          hs   = mreq && mgnt;
          egnt = hs ? (N'(1) << w) : '0;
          pop  = mrv && (m_q[m].size() > 0);
          erv  = pop ? (N'(1) << m_q[m][0]) : '0;
          eux  = mrv && (m_q[m].size() == 0);
          chk({p, "_mem_req"}, a_mreq, mreq);
          chk({p, "_gnt"}, a_gnt, egnt);
          chk({p, "_rvalid"}, a_rv, erv);
          chk({p, "_unexp"}, a_ux, eux);
          chk({p, "_rdata"}, a_rd, mrdata);
          if (mreq) begin
            chk({p, "_mem_addr"}, a_ma, addr[w*AW +: AW]);
            chk({p, "_mem_we"}, a_we, we[w]);
            chk({p, "_mem_be"}, a_be, be[w*BW +: BW]);
            chk({p, "_mem_wdata"}, a_mw, wdata[w*DW +: DW]);
          end
          if (pop) void'(m_q[m].pop_front());
          if (hs) begin
            m_q[m].push_back(w);
            m_lock[m] = 1'b0;
            if (m == 0) m_ptr[m] = (w + 1) % N;
          end else if (mreq) begin
            m_lock[m] = 1'b1;
            m_lidx[m] = w;
          end
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] r, input logic g,
                      input logic rv, input logic [DW-1:0] rd);
    @(posedge clk);
    #1;
    req = r;
    mgnt = g;
    mrv = rv;
    mrdata = rd;
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] eg, ep;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i) * 32'h100;
      wdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      be[i*BW +: BW]    = 4'hF - 4'(i);
      we[i]             = i[0];
    end
    repeat (2) @(negedge clk);
    chk("rst_rvalid", rv_r, 3'b000);
    chk("rst_unexp", ux_r, 1'b0);
    chk("rst_mem_req", mreq_r, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // T1 round-robin fairness with 1-cycle memory
    step(3'b111, 1'b1, 1'b0, '0);
    chk("t1_gnt", gnt_r, 3'b001);
    ep = 3'b001;
    for (int i = 1; i < 6; i++) begin
      step(3'b111, 1'b1, 1'b1, '0);
      eg = 3'b001;
      eg = eg << (i % 3);
      chk("t1_gnt", gnt_r, eg);
      chk("t1_rvalid", rv_r, ep);
      ep = eg;
    end
    step(3'b000, 1'b0, 1'b1, '0);
    chk("t1_rvalid_last", rv_r, 3'b100);

    // T2 fixed priority
    step(3'b110, 1'b1, 1'b0, '0);
    chk("t2_fp_gnt1", gnt_f, 3'b010);
    repeat (3) begin
      step(3'b111, 1'b1, 1'b1, '0);
      chk("t2_fp_gnt0", gnt_f, 3'b001);
    end
    step(3'b000, 1'b0, 1'b1, '0);

    // T3 stall lock on port 2
    step(3'b100, 1'b0, 1'b0, '0);
    chk("t3_addr", ma_r, 32'h1000_0200);
    repeat (2) begin
      step(3'b101, 1'b0, 1'b0, '0);
      chk("t3_addr_held", ma_r, 32'h1000_0200);
      chk("t3_no_gnt", gnt_r, 3'b000);
    end
    step(3'b101, 1'b1, 1'b0, '0);
    chk("t3_gnt2", gnt_r, 3'b100);
    chk("t3_fp_gnt2", gnt_f, 3'b100);
    step(3'b001, 1'b1, 1'b1, '0);
    chk("t3_gnt0", gnt_r, 3'b001);
    chk("t3_rvalid2", rv_r, 3'b100);
    step(3'b000, 1'b0, 1'b1, '0);
    chk("t3_rvalid0", rv_r, 3'b001);

    // T4 outstanding limit
    step(3'b111, 1'b1, 1'b0, '0);
    chk("t4_gnt1", gnt_r, 3'b010);
    step(3'b111, 1'b1, 1'b0, '0);
    chk("t4_gnt2", gnt_r, 3'b100);
    repeat (2) begin
      step(3'b111, 1'b1, 1'b0, '0);
      chk("t4_full_req", mreq_r, 1'b0);
      chk("t4_full_gnt", gnt_r, 3'b000);
    end
    step(3'b111, 1'b1, 1'b1, '0);
    chk("t4_nobypass", mreq_r, 1'b0);
    chk("t4_rvalid", rv_r, 3'b010);
    step(3'b111, 1'b1, 1'b0, '0);
    chk("t4_release", gnt_r, 3'b001);
    step(3'b111, 1'b1, 1'b0, '0);
    chk("t4_refull", mreq_r, 1'b0);
    step(3'b000, 1'b0, 1'b1, '0);
    chk("t4_drain_a", rv_r, 3'b100);
    step(3'b000, 1'b0, 1'b1, '0);
    chk("t4_drain_b", rv_r, 3'b001);

    // T5 response routing
    step(3'b010, 1'b1, 1'b0, '0);
    chk("t5_gnt1", gnt_r, 3'b010);
    step(3'b001, 1'b1, 1'b0, '0);
    chk("t5_gnt0", gnt_r, 3'b001);
    step(3'b000, 1'b0, 1'b1, 32'hAAAA_0001);
    chk("t5_rvalid1", rv_r, 3'b010);
    chk("t5_rdata1", rd_r, 32'hAAAA_0001);
    step(3'b000, 1'b0, 1'b1, 32'hBBBB_0000);
    chk("t5_rvalid0", rv_r, 3'b001);
    chk("t5_rdata0", rd_r, 32'hBBBB_0000);

    // T6 reset with two outstanding, pointer left at 2
    step(3'b010, 1'b1, 1'b0, '0);
    step(3'b010, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    mgnt = 1'b0;
    mrv = 1'b0;
    @(negedge clk);
    chk("t6_rst_rvalid", rv_r, 3'b000);
    chk("t6_rst_mem_req", mreq_r, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3'b000, 1'b0, 1'b1, 32'h5555_5555);
    chk("t6_unexp", ux_r, 1'b1);
    chk("t6_fp_unexp", ux_f, 1'b1);
    chk("t6_no_rvalid", rv_r, 3'b000);
    step(3'b111, 1'b1, 1'b0, '0);
    chk("t6_ptr0", gnt_r, 3'b001);
    step(3'b000, 1'b0, 1'b1, '0);

    // randomized traffic; a port changes nothing while either instance holds it locked
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!(m_lock[0] && m_lidx[0] == i) && !(m_lock[1] && m_lidx[1] == i)) begin
          req[i]            = ($urandom_range(0, 9) < 6);
          we[i]             = 1'($urandom);
          addr[i*AW +: AW]  = $urandom;
          be[i*BW +: BW]    = 4'($urandom);
          wdata[i*DW +: DW] = $urandom;
        end
      end
      mgnt   = ($urandom_range(0, 9) < 7);
      mrv    = ($urandom_range(0, 9) < 5);
      mrdata = $urandom;
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
